// File: rtl/ram_byte_responder_pkg.sv
// ram_byte_responder_pkg: shared bus encodings, IO map and address decode
package ram_byte_responder_pkg;
  localparam logic        RAM_READ     = 1'b0;
  localparam logic        RAM_WRITE    = 1'b1;
  localparam int          RAM_RW_WIDTH = 8;
  localparam logic        ENABLE       = 1'b1;
  localparam logic        DISABLE      = 1'b0;
  localparam logic [7:0]  NULL         = 8'h00;
  localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR = 18'h30004;
  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_HOLE} region_e;
  function automatic region_e decode(input logic [1:0] hi);
    return !hi[1] ? REG_RAM : hi[0] ? REG_IO : REG_HOLE;
  endfunction
endpackage

// File: rtl/ram_byte_responder_io_tx_fifo.sv
// io_tx_fifo: byte TX FIFO with valid/ready drain and sticky overflow
module io_tx_fifo
  import ram_byte_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_PTR_W = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  en,
  input  logic                  push,
  input  logic [RAM_RW_WIDTH-1:0] wdata,
  input  logic                  ready,
  output logic                  valid,
  output logic [RAM_RW_WIDTH-1:0] data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_PTR_W:0]   count,
  output logic                  overflow
);
  logic [RAM_RW_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr, rd_ptr;
  logic pop, acc, drop;
  assign empty = count == '0;
  assign full  = count == (FIFO_PTR_W+1)'(FIFO_DEPTH);
  assign valid = !empty;
  assign data  = mem_q[rd_ptr];
  assign pop   = en && valid && ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign acc   = en && push && (!full || pop);
  assign drop  = en && push && full && !pop;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= DISABLE;
    end else begin
      if (acc) begin
        mem_q[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FIFO_PTR_W+1)'(acc) - (FIFO_PTR_W+1)'(pop);
      if (drop) overflow <= ENABLE;
    end
  end
endmodule

// File: rtl/ram_byte_responder.sv
// ram_byte_responder: byte RAM with one-cycle reads, IO TX FIFO window and halt pulse
module ram_byte_responder
  import ram_byte_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_PTR_W = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    ram_rw_in,
  input  logic [31:0]             ram_addr_in,
  input  logic [RAM_RW_WIDTH-1:0] ram_wdata_in,
  output logic [RAM_RW_WIDTH-1:0] ram_rdata_out,
  output logic                    io_buffer_full_out,
  output logic                    sim_halt_out,
  output logic                    uart_tx_valid_out,
  output logic [RAM_RW_WIDTH-1:0] uart_tx_data_out,
  input  logic                    uart_tx_ready_in
);
  logic [RAM_RW_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [RAM_RW_WIDTH-1:0] rd_val;
  logic [FIFO_PTR_W:0] fifo_count;
  logic [17:0] a;
  region_e region;
  logic io_wr, push, halt_wr, overflow, empty, unused_bits;
  assign a           = ram_addr_in[17:0];
  assign region      = decode(a[17:16]);
  assign io_wr       = rdy_in && ram_rw_in == RAM_WRITE && region == REG_IO;
  assign push        = io_wr && a == IO_TX_ADDR;
  assign halt_wr     = io_wr && a == IO_HALT_ADDR;
  assign unused_bits = ^{ram_addr_in[31:18], fifo_count, empty};
  assign rd_val = region == REG_RAM ? mem[ram_addr_in[ADDR_WIDTH-1:0]] :
                  (region == REG_IO && a == IO_HALT_ADDR) ? {6'b0, overflow, io_buffer_full_out} : NULL;
  always_ff @(posedge clk_in)
    if (rdy_in && ram_rw_in == RAM_WRITE && region == REG_RAM) mem[ram_addr_in[ADDR_WIDTH-1:0]] <= ram_wdata_in;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ram_rdata_out <= NULL;
      sim_halt_out  <= DISABLE;
    end else begin
      if (rdy_in && ram_rw_in == RAM_READ) ram_rdata_out <= rd_val;
      sim_halt_out <= halt_wr;
    end
  end
  io_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_PTR_W(FIFO_PTR_W)) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in),
    .push     (push),
    .wdata    (ram_wdata_in),
    .ready    (uart_tx_ready_in),
    .valid    (uart_tx_valid_out),
    .data     (uart_tx_data_out),
    .full     (io_buffer_full_out),
    .empty    (empty),
    .count    (fifo_count),
    .overflow (overflow)
  );
endmodule

// File: tb/tb_ram_byte_responder.sv
// tb_ram_byte_responder: table-driven RAM checks plus FIFO, halt and reset sequences
module tb_ram_byte_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic ram_rw_in = 1'b0;
  logic [31:0] ram_addr_in = '0;
  logic [7:0] ram_wdata_in = '0;
  logic [7:0] ram_rdata_out;
  logic io_buffer_full_out, sim_halt_out, uart_tx_valid_out, uart_tx_ready_in;
  logic [7:0] uart_tx_data_out;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt[19];
  logic [7:0] exp_q[8];

  ram_byte_responder dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .ram_rw_in          (ram_rw_in),
    .ram_addr_in        (ram_addr_in),
    .ram_wdata_in       (ram_wdata_in),
    .ram_rdata_out      (ram_rdata_out),
    .io_buffer_full_out (io_buffer_full_out),
    .sim_halt_out       (sim_halt_out),
    .uart_tx_valid_out  (uart_tx_valid_out),
    .uart_tx_data_out   (uart_tx_data_out),
    .uart_tx_ready_in   (uart_tx_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rw, input logic [31:0] addr, input logic [7:0] wd);
    ram_rw_in = rw;
    ram_addr_in = addr;
    ram_wdata_in = wd;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    uart_tx_ready_in = 1'b0;
    vt[0]  = '{1'b1, 32'h00100,    8'h11, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 32'h00101,    8'h22, 1'b0, 8'h00};
    vt[2]  = '{1'b1, 32'h00102,    8'h33, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 32'h00103,    8'h44, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 32'h00100,    8'h00, 1'b1, 8'h11};
    vt[5]  = '{1'b0, 32'h00101,    8'h00, 1'b1, 8'h22};
    vt[6]  = '{1'b0, 32'h00102,    8'h00, 1'b1, 8'h33};
    vt[7]  = '{1'b0, 32'h00103,    8'h00, 1'b1, 8'h44};
    vt[8]  = '{1'b1, 32'h1FFFF,    8'h5A, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 32'h1FFFF,    8'h00, 1'b1, 8'h5A};
    vt[10] = '{1'b1, 32'h00010,    8'h99, 1'b0, 8'h00};
    vt[11] = '{1'b0, 32'h20010,    8'h00, 1'b1, 8'h00};
    vt[12] = '{1'b1, 32'h20010,    8'h77, 1'b0, 8'h00};
    vt[13] = '{1'b0, 32'h00010,    8'h00, 1'b1, 8'h99};
    vt[14] = '{1'b1, 32'hFFFC0200, 8'hAB, 1'b0, 8'h00};
    vt[15] = '{1'b0, 32'h00200,    8'h00, 1'b1, 8'hAB};
    vt[16] = '{1'b0, 32'h30000,    8'h00, 1'b1, 8'h00};
    vt[17] = '{1'b0, 32'h00103,    8'h00, 1'b1, 8'h44};
    vt[18] = '{1'b0, 32'h30004,    8'h00, 1'b1, 8'h00};
    #12;
    chk("reset_rdata", ram_rdata_out, 0);
    chk("reset_full", io_buffer_full_out, 0);
    chk("reset_valid", uart_tx_valid_out, 0);
    chk("reset_data", uart_tx_data_out, 0);
    chk("reset_halt", sim_halt_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 19; i++) begin
      cyc(vt[i].rw, vt[i].addr, vt[i].wdata);
      if (vt[i].chk) chk($sformatf("vec%0d_rdata", i), ram_rdata_out, vt[i].exp);
    end
    // rdy low: read must hold, write must not land
    rdy_in = 1'b0;
    cyc(1'b1, 32'h00100, 8'hEE);
    cyc(1'b0, 32'h00101, 8'h00);
    chk("rdy0_hold", ram_rdata_out, 8'h00);
    rdy_in = 1'b1;
    cyc(1'b0, 32'h00100, 8'h00);
    chk("rdy0_no_write", ram_rdata_out, 8'h11);
    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h30000, 8'h61 + 8'(i));
    chk("sim_full_before", io_buffer_full_out, 1);
    uart_tx_ready_in = 1'b1;
    cyc(1'b1, 32'h30000, 8'h5A);
    chk("sim_full_after", io_buffer_full_out, 1);
    uart_tx_ready_in = 1'b0;
    cyc(1'b0, 32'h30004, 8'h00);
    chk("sim_status", ram_rdata_out, 8'h01);
    for (int i = 0; i < 7; i++) exp_q[i] = 8'h62 + 8'(i);
    exp_q[7] = 8'h5A;
    uart_tx_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sim_valid%0d", i), uart_tx_valid_out, 1);
      chk($sformatf("sim_data%0d", i), uart_tx_data_out, exp_q[i]);
      cyc(1'b0, 32'h0, 8'h00);
    end
    chk("sim_drained", uart_tx_valid_out, 0);
    // overflow: nine pushes with UART stalled
    uart_tx_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 32'h30000, 8'h41 + 8'(i));
      if (i == 6) chk("ovf_full7", io_buffer_full_out, 0);
      if (i == 7) chk("ovf_full8", io_buffer_full_out, 1);
    end
    chk("ovf_full9", io_buffer_full_out, 1);
    cyc(1'b0, 32'h30004, 8'h00);
    chk("ovf_status", ram_rdata_out, 8'h03);
    uart_tx_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_data%0d", i), uart_tx_data_out, 8'h41 + 8'(i));
      cyc(1'b0, 32'h0, 8'h00);
    end
    chk("ovf_drained", uart_tx_valid_out, 0);
    cyc(1'b0, 32'h30004, 8'h00);
    chk("ovf_sticky", ram_rdata_out, 8'h02);
    // halt pulse
    cyc(1'b1, 32'h30004, 8'h00);
    chk("halt_pulse", sim_halt_out, 1);
    cyc(1'b0, 32'h0, 8'h00);
    chk("halt_one_cycle", sim_halt_out, 0);
    rdy_in = 1'b0;
    cyc(1'b1, 32'h30004, 8'h00);
    chk("halt_rdy0", sim_halt_out, 0);
    rdy_in = 1'b1;
    // async reset with 5 queued bytes
    uart_tx_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h30000, 8'h30 + 8'(i));
    chk("rst_pre_valid", uart_tx_valid_out, 1);
    ram_rw_in = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("rst_valid", uart_tx_valid_out, 0);
    chk("rst_full", io_buffer_full_out, 0);
    chk("rst_rdata", ram_rdata_out, 0);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    cyc(1'b0, 32'h1FFFF, 8'h00);
    chk("rst_ram_kept", ram_rdata_out, 8'h5A);
    cyc(1'b0, 32'h30004, 8'h00);
    chk("rst_ovf_clear", ram_rdata_out, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
